// File: rtl/counter_pkg.sv
// Shared widths, extended-count type and snapshot FSM states for the wrap extender.
package counter_pkg;
  localparam int LOW_W      = 4;
  localparam int WRAP_W_DEF = 12;
  localparam int EXT_W_DEF  = LOW_W + WRAP_W_DEF;

  typedef logic [EXT_W_DEF-1:0] ext_count_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } snap_state_t;
endpackage

// File: rtl/counter_wrap_extender_if.sv
// Snapshot readout handshake; master drives valid/data/miss, slave drives req/ready.
interface counter_wrap_extender_if
  import counter_pkg::*;
#(
  parameter int DATA_W = EXT_W_DEF
);
  logic              snap_req;
  logic              snap_valid;
  logic [DATA_W-1:0] snap_data;
  logic              snap_ready;
  logic              snap_miss;

  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data,
    output snap_miss
  );

  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data,
    input  snap_miss
  );
endinterface

// File: rtl/wrap_edge_counter.sv
// Rising-edge detect on overflow plus saturating wrap counter; wrap_next is combinational
// (the value the count takes this edge), wrap_sat registered. No backpressure.
module wrap_edge_counter
  import counter_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              overflow_in,
  input  logic              clr,
  output logic [WRAP_W-1:0] wrap_next,
  output logic              wrap_sat
);
  logic              ov_q;
  logic              rise;
  logic              sat_next;
  logic [WRAP_W-1:0] wrap_count;

  assign rise = overflow_in & ~ov_q;

  // clr beats a coincident rise; at all-ones the count holds and only the flag moves.
  always_comb begin
    wrap_next = wrap_count;
    sat_next  = wrap_sat;
    if (clr) begin
      wrap_next = '0;
      sat_next  = 1'b0;
    end else if (rise) begin
      if (&wrap_count) begin
        sat_next = 1'b1;
      end else begin
        wrap_next = wrap_count + WRAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ov_q       <= 1'b0;
      wrap_count <= '0;
      wrap_sat   <= 1'b0;
    end else begin
      ov_q       <= overflow_in;
      wrap_count <= wrap_next;
      wrap_sat   <= sat_next;
    end
  end
endmodule

// File: rtl/counter_wrap_extender.sv
// Extends a 4-bit counter with a wrap count, sticky threshold alarm and snapshot port.
// ext_count 1-cycle latency; snapshot held until snap_ready, requests during hold are dropped.
module counter_wrap_extender
  import counter_pkg::*;
#(
  parameter int                       WRAP_W = WRAP_W_DEF,
  parameter logic [LOW_W+WRAP_W-1:0]  THRESH = 16'h0100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LOW_W-1:0]        counter_in,
  input  logic                    overflow_in,
  input  logic                    clr,
  input  logic                    alarm_clr,
  output logic [LOW_W+WRAP_W-1:0] ext_count,
  output logic                    wrap_sat,
  output logic                    alarm,
  counter_wrap_extender_if.master snap
);
  localparam int EXT_W = LOW_W + WRAP_W;

  logic [WRAP_W-1:0] wrap_next;
  logic [EXT_W-1:0]  ext_next;
  logic              alarm_next;

  snap_state_t       state;
  snap_state_t       state_next;
  logic              valid_next;
  logic [EXT_W-1:0]  data_next;
  logic              miss_next;

  wrap_edge_counter #(.WRAP_W(WRAP_W)) u_wrap (
    .clk         (clk),
    .reset       (reset),
    .overflow_in (overflow_in),
    .clr         (clr),
    .wrap_next   (wrap_next),
    .wrap_sat    (wrap_sat)
  );

  // Using the incoming high field keeps the 15->16 transition glitch-free.
  assign ext_next = {wrap_next, counter_in};

  always_comb begin
    alarm_next = alarm;
    if (ext_next >= THRESH) begin
      alarm_next = 1'b1;
    end else if (alarm_clr || clr) begin
      alarm_next = 1'b0;
    end
  end

  always_comb begin
    state_next = state;
    valid_next = snap.snap_valid;
    data_next  = snap.snap_data;
    miss_next  = snap.snap_miss;
    case (state)
      IDLE: begin
        if (snap.snap_req) begin
          data_next  = ext_next;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (snap.snap_req) begin
          miss_next = 1'b1;
        end
        if (snap.snap_valid && snap.snap_ready) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_count       <= '0;
      alarm           <= 1'b0;
      state           <= IDLE;
      snap.snap_valid <= 1'b0;
      snap.snap_data  <= '0;
      snap.snap_miss  <= 1'b0;
    end else begin
      ext_count       <= ext_next;
      alarm           <= alarm_next;
      state           <= state_next;
      snap.snap_valid <= valid_next;
      snap.snap_data  <= data_next;
      snap.snap_miss  <= miss_next;
    end
  end
endmodule
